// File: rtl/space_key_tracker.sv
// space_key_tracker: PS/2 scan-code decoder for the space bar.
// Emits debounced press/release events through a 2-deep ack queue.
module space_key_tracker #(
  parameter logic [7:0]  KEY_CODE = 8'h29,
  parameter logic [19:0] TIMEOUT  = 20'd500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_ready,
  input  logic       reset_space_state,
  output logic [1:0] space_state,
  output logic       key_held,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } state_t;

  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;
  localparam logic [1:0] EV_PRESS = 2'd1;
  localparam logic [1:0] EV_REL   = 2'd2;

  state_t      state_q;
  logic [19:0] idle_q;
  logic        held_q;
  logic        ovf_q;
  logic        ack_q;
  logic [1:0]  q0_q;
  logic [1:0]  q1_q;
  logic [1:0]  cnt_q;

  logic        make_d;
  logic        brk_d;
  logic        push_d;
  logic        pop_d;
  logic [1:0]  val_d;

  // Classify the current byte as a make or break of the tracked key
  always_comb begin
    make_d = 1'b0;
    brk_d  = 1'b0;
    if (scan_ready) begin
      unique case (state_q)
        IDLE:    make_d = (scan_code == KEY_CODE);
        BRK:     brk_d  = (scan_code == KEY_CODE);
        default: ;
      endcase
    end
  end

  // Held-state filter and ack edge detection decide push/pop
  always_comb begin
    push_d = (make_d & ~held_q) | (brk_d & held_q);
    val_d  = make_d ? EV_PRESS : EV_REL;
    pop_d  = reset_space_state & ~ack_q & (cnt_q != 2'd0);
  end

  // Prefix decoder with idle timeout back to IDLE
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idle_q  <= 20'd0;
    end else if (scan_ready) begin
      idle_q <= 20'd0;
      unique case (state_q)
        IDLE: begin
          if (scan_code == BRK_CODE)
            state_q <= BRK;
          else if (scan_code == EXT_CODE)
            state_q <= EXT;
          else
            state_q <= IDLE;
        end
        BRK:     state_q <= IDLE;
        EXT: begin
          if (scan_code == BRK_CODE)
            state_q <= EXT_BRK;
          else
            state_q <= IDLE;
        end
        EXT_BRK: state_q <= IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (idle_q == TIMEOUT - 20'd1) begin
        state_q <= IDLE;
        idle_q  <= 20'd0;
      end else begin
        idle_q <= idle_q + 20'd1;
      end
    end else begin
      idle_q <= 20'd0;
    end
  end

  // Key-down flag follows accepted make/break events
  always_ff @(posedge clock) begin
    if (reset)
      held_q <= 1'b0;
    else if (make_d)
      held_q <= 1'b1;
    else if (brk_d)
      held_q <= 1'b0;
  end

  // Event queue; head kept in q0, empty slots kept at zero
  always_ff @(posedge clock) begin
    if (reset) begin
      q0_q  <= 2'd0;
      q1_q  <= 2'd0;
      cnt_q <= 2'd0;
      ovf_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      ack_q <= reset_space_state;
      if (push_d && pop_d) begin
        if (cnt_q == 2'd2) begin
          q0_q <= q1_q;
          q1_q <= val_d;
        end else begin
          q0_q <= val_d;
        end
      end else if (pop_d) begin
        q0_q  <= q1_q;
        q1_q  <= 2'd0;
        cnt_q <= cnt_q - 2'd1;
      end else if (push_d) begin
        if (cnt_q == 2'd0) begin
          q0_q  <= val_d;
          cnt_q <= 2'd1;
        end else if (cnt_q == 2'd1) begin
          q1_q  <= val_d;
          cnt_q <= 2'd2;
        end else begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  assign space_state = q0_q;
  assign key_held    = held_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_space_key_tracker.sv
// tb_space_key_tracker: vector table plus scoreboard queue
// for the space-bar event tracker.
module tb_space_key_tracker;

  localparam logic [19:0] TMO = 20'd16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_ready = 1'b0;
  logic       ack = 1'b0;
  logic [1:0] space_state;
  logic       key_held;
  logic       overflow;

  int total = 0;
  int bad = 0;

  typedef struct {
    string      name;
    logic       rst;
    logic       rdy;
    logic [7:0] code;
    logic       ack;
    logic [1:0] ss;
    logic       held;
    logic       ovf;
  } vec_t;

  typedef struct {
    string      name;
    logic [1:0] ss;
    logic       held;
    logic       ovf;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  space_key_tracker #(
    .KEY_CODE(8'h29),
    .TIMEOUT (TMO)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .scan_code        (scan_code),
    .scan_ready       (scan_ready),
    .reset_space_state(ack),
    .space_state      (space_state),
    .key_held         (key_held),
    .overflow         (overflow)
  );

  always #5 clock = ~clock;

  task automatic add(input string n, input logic r,
                     input logic rd, input logic [7:0] c,
                     input logic a, input logic [1:0] s,
                     input logic h, input logic o);
    vec_t v;
    v.name = n; v.rst = r; v.rdy = rd; v.code = c;
    v.ack = a; v.ss = s; v.held = h; v.ovf = o;
    vecs.push_back(v);
  endtask

  task automatic step(input string n, input logic r,
                      input logic rd, input logic [7:0] c,
                      input logic a, input logic [1:0] s,
                      input logic h, input logic o);
    exp_t e;
    exp_t g;
    reset = r;
    scan_ready = rd;
    scan_code = c;
    ack = a;
    e.name = n; e.ss = s; e.held = h; e.ovf = o;
    sb.push_back(e);
    @(posedge clock);
    #1;
    g = sb.pop_front();
    total++;
    if (space_state !== g.ss || key_held !== g.held ||
        overflow !== g.ovf) begin
      bad++;
      $display("FAIL %s: got ss=%0d held=%0b ovf=%0b want ss=%0d held=%0b ovf=%0b",
               g.name, space_state, key_held, overflow,
               g.ss, g.held, g.ovf);
    end
  endtask

  initial begin
    add("rst0",    1, 0, 8'h00, 0, 0, 0, 0);
    add("rst1",    1, 0, 8'h00, 0, 0, 0, 0);
    add("pr_mk",   0, 1, 8'h29, 0, 1, 1, 0);
    add("pr_f0",   0, 1, 8'hF0, 0, 1, 1, 0);
    add("pr_brk",  0, 1, 8'h29, 0, 1, 0, 0);
    add("pr_ack1", 0, 0, 8'h00, 1, 2, 0, 0);
    add("pr_lo1",  0, 0, 8'h00, 0, 2, 0, 0);
    add("pr_ack2", 0, 0, 8'h00, 1, 0, 0, 0);
    add("pr_hold", 0, 0, 8'h00, 1, 0, 0, 0);
    add("pr_lo2",  0, 0, 8'h00, 0, 0, 0, 0);
    add("ty_mk1",  0, 1, 8'h29, 0, 1, 1, 0);
    add("ty_mk2",  0, 1, 8'h29, 0, 1, 1, 0);
    add("ty_ack1", 0, 0, 8'h00, 1, 0, 1, 0);
    add("ty_mk3",  0, 1, 8'h29, 0, 0, 1, 0);
    add("ty_mk4",  0, 1, 8'h29, 0, 0, 1, 0);
    add("ty_mk5",  0, 1, 8'h29, 0, 0, 1, 0);
    add("ty_f0",   0, 1, 8'hF0, 0, 0, 1, 0);
    add("ty_brk",  0, 1, 8'h29, 0, 2, 0, 0);
    add("ty_ack2", 0, 0, 8'h00, 1, 0, 0, 0);
    add("ty_lo",   0, 0, 8'h00, 0, 0, 0, 0);
    add("ov_mk",   0, 1, 8'h29, 0, 1, 1, 0);
    add("ov_f0",   0, 1, 8'hF0, 0, 1, 1, 0);
    add("ov_brk",  0, 1, 8'h29, 0, 1, 0, 0);
    add("ov_drop", 0, 1, 8'h29, 0, 1, 1, 1);
    add("ov_ack1", 0, 0, 8'h00, 1, 2, 1, 1);
    add("ov_lo1",  0, 0, 8'h00, 0, 2, 1, 1);
    add("ov_ack2", 0, 0, 8'h00, 1, 0, 1, 1);
    add("ov_lo2",  0, 0, 8'h00, 0, 0, 1, 1);
    add("ov_ack3", 0, 0, 8'h00, 1, 0, 1, 1);
    add("ov_rst",  1, 0, 8'h00, 0, 0, 0, 0);
    add("fl_e0a",  0, 1, 8'hE0, 0, 0, 0, 0);
    add("fl_e29",  0, 1, 8'h29, 0, 0, 0, 0);
    add("fl_e0b",  0, 1, 8'hE0, 0, 0, 0, 0);
    add("fl_ef0",  0, 1, 8'hF0, 0, 0, 0, 0);
    add("fl_ef29", 0, 1, 8'h29, 0, 0, 0, 0);
    add("fl_f0a",  0, 1, 8'hF0, 0, 0, 0, 0);
    add("fl_1c",   0, 1, 8'h1C, 0, 0, 0, 0);
    add("fl_f0b",  0, 1, 8'hF0, 0, 0, 0, 0);
    add("fl_stry", 0, 1, 8'h29, 0, 0, 0, 0);
    add("fl_oth",  0, 1, 8'h1C, 0, 0, 0, 0);
    add("mr_mk",   0, 1, 8'h29, 0, 1, 1, 0);
    add("mr_ack",  0, 0, 8'h00, 1, 0, 1, 0);
    add("mr_lo",   0, 0, 8'h00, 0, 0, 1, 0);
    add("mr_f0",   0, 1, 8'hF0, 0, 0, 1, 0);
    add("mr_rst",  1, 0, 8'h00, 0, 0, 0, 0);
    add("mr_mk2",  0, 1, 8'h29, 0, 1, 1, 0);
    add("sc_f0",   0, 1, 8'hF0, 0, 1, 1, 0);
    add("sc_both", 0, 1, 8'h29, 1, 2, 0, 0);
    add("sc_lo",   0, 0, 8'h00, 0, 2, 0, 0);
    add("sc_ack",  0, 0, 8'h00, 1, 0, 0, 0);
    add("sc_lo2",  0, 0, 8'h00, 0, 0, 0, 0);

    foreach (vecs[i])
      step(vecs[i].name, vecs[i].rst, vecs[i].rdy,
           vecs[i].code, vecs[i].ack, vecs[i].ss,
           vecs[i].held, vecs[i].ovf);

    step("to_rst", 1, 0, 8'h00, 0, 0, 0, 0);
    step("to_f0", 0, 1, 8'hF0, 0, 0, 0, 0);
    for (int i = 0; i < int'(TMO); i++)
      step("to_wait", 0, 0, 8'h00, 0, 0, 0, 0);
    step("to_mk", 0, 1, 8'h29, 0, 1, 1, 0);

    step("tb_ack", 0, 0, 8'h00, 1, 0, 1, 0);
    step("tb_lo", 0, 0, 8'h00, 0, 0, 1, 0);
    step("tb_f0", 0, 1, 8'hF0, 0, 0, 1, 0);
    for (int i = 0; i < int'(TMO) - 2; i++)
      step("tb_wait", 0, 0, 8'h00, 0, 0, 1, 0);
    step("tb_brk", 0, 1, 8'h29, 0, 2, 0, 0);
    step("tb_ack2", 0, 0, 8'h00, 1, 0, 0, 0);
    step("tb_lo2", 0, 0, 8'h00, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
